tow_match_ctrl: RTL and testbench
=================================

# tow_match_ctrl

Match controller sitting directly downstream of the tug-of-war round engine (`top`). It consumes the engine's round result signals `winrnd`, `right` and `tie`, keeps per-player round scores and a tie count, and declares a best-of match winner. It also generates the `clr` pulse that re-arms the round engine for the next round. It replaces the manual `clr` toggling done in simulation with a self-sequencing match flow.

## Interface
- `WIN_ROUNDS`, default 3: rounds a player must win to take the match (1..2^SCORE_W-1).
- `SCORE_W`, default 3: width of each score counter.
- `CLR_DELAY`, default 8: cycles the round result is displayed before `clr` is pulsed (≥1).
- `TIE_W`, default 4: width of the tie counter.
- `clk`  in  1: single system clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-low reset.
- `start`  in  1: request a new match; honoured only in IDLE or DONE.
- `winrnd`  in  1: round decided; level, held by the engine until `clr`.
- `right`  in  1: right player won; valid while `winrnd`=1.
- `tie`  in  1: round tied; valid while `winrnd`=1; overrides `right`.
- `clr`  out  1: one-cycle round-clear pulse to the round engine.
- `score_l`  out  SCORE_W: left rounds won.
- `score_r`  out  SCORE_W: right rounds won.
- `tie_cnt`  out  TIE_W: tied rounds, saturating at all-ones.
- `match_over`  out  1: high in DONE.
- `match_right`  out  1: match winner is right; valid while `match_over`=1.

## Operation
- States: IDLE, PLAY, HOLD, CLEAR, DONE.
- Reset (`rst`=0 at an edge):
  - state→IDLE.
  - All outputs 0.
  - `winrnd_q`←0.
  - Delay counter←0.
- `winrnd_q` registers `winrnd` every cycle in every state. `rise` = `winrnd & ~winrnd_q`.
- IDLE / DONE, `start`=1:
  - Clear `score_l`, `score_r`, `tie_cnt`, `match_right`.
  - state→CLEAR.
  - `match_over` drops with the state change.
- PLAY, `rise`=1:
  - If `tie`: `tie_cnt`+1, saturating.
  - Else if `right`: `score_r`+1.
  - Else: `score_l`+1.
  - If the incremented score equals WIN_ROUNDS: state→DONE and `match_right`←`right`.
  - Otherwise: state→HOLD and the delay counter is loaded with CLR_DELAY-1.
- HOLD: the counter decrements each cycle. When the counter is 0, state→CLEAR.
- CLEAR: `clr`=1. state→PLAY unconditionally.
- Ignored inputs:
  - `rise` outside PLAY is ignored. A level still high on return to PLAY produces no rise, so there is no double count.
  - `start` in PLAY, HOLD or CLEAR is ignored.
- Scores never exceed WIN_ROUNDS. A tie never ends the match.

## Timing
- Outputs are registered or decoded from the registered state only. There are no combinational paths from inputs to outputs.
- Round scoring: `winrnd` first high before edge k → score and state update at edge k (latency 1 edge).
- Clear pulse: HOLD spans edges k..k+CLR_DELAY-1. `clr` is high for exactly one cycle, from edge k+CLR_DELAY to edge k+CLR_DELAY+1.
- Match start: `start` at edge s → `clr` high from edge s to s+1, and PLAY from s+1.
- Match end: the winning round sets `match_over` at the same edge as the score update. No `clr` is issued until the next `start`.
- Reset asserted mid-HOLD or mid-CLEAR: IDLE at that edge. `clr` low from that edge on; no partial pulse continues.
- Reset dominates `start` at the same edge.
- `tie`=1 together with `right`=1 counts as a tie only.

## Structure
- Shared package `tow_pkg`:
  - State enum/encoding (IDLE=0, PLAY=1, HOLD=2, CLEAR=3, DONE=4; 3 bits).
  - Default widths.
  - CLR_DELAY default.
- Sub-module `tow_rise_det`:
  - Registered rising-edge detector.
  - Synchronous active-low reset.
  - Ports `clk`, `rst`, `d`, `rise`.
  - Reused for button conditioning elsewhere.
- Delay counter and FSM are inline in `tow_match_ctrl`.

## Test plan
Parameters: WIN_ROUNDS=3, CLR_DELAY=4.
- **Reset:** `rst`=0 for 2 cycles with `winrnd`=1 → all outputs 0, state IDLE. Releasing reset with `winrnd` still high → no score change.
- **Single round:** `start` pulse, then `winrnd`=1, `right`=1 held 10 cycles → `score_r`=1 one edge after the rise. `clr` high exactly 1 cycle, 4 cycles later. No second increment.
- **Match win:** three right wins, each followed by `winrnd` dropping after `clr` → `score_r`=3, `match_over`=1, `match_right`=1. Then no `clr` for 20 cycles.
- **Ties:**
  - `tie`=1 with `right`=1 → `tie_cnt`=1, scores unchanged.
  - 16 tie rounds → `tie_cnt` saturates at 15.
- **Mixed match:** left, right, left, tie, left → `score_l`=3, `score_r`=1, `tie_cnt`=1, `match_right`=0. A new `start` clears all three and pulses `clr`.
- **Reset during HOLD:** `rst`=0 two cycles into HOLD → `clr` never pulses, IDLE. `start` in PLAY → ignored, scores unchanged.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared definitions for the tug-of-war match controller slice.
package tow_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    HOLD  = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } tow_state_t;

  localparam int DEF_WIN_ROUNDS = 3;
  localparam int DEF_SCORE_W    = 3;
  localparam int DEF_TIE_W      = 4;
  localparam int DEF_CLR_DELAY  = 8;

  // Width needed to hold a down-counter preload of d-1 (never narrower than 1 bit).
  function automatic int cntWidth(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage

// File: rtl/tow_rise_det.sv
// Registered rising-edge detector: rise is high while d is high and was low last cycle.
module tow_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic r_d_q;

  // Remember the previous level of d; cleared by the active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) r_d_q <= 1'b0;
    else      r_d_q <= d;
  end

  assign rise = d & ~r_d_q;

endmodule

// File: rtl/tow_match_ctrl.sv
// Best-of match controller: scores rounds from the round engine and sequences its clr pulse.
module tow_match_ctrl
  import tow_pkg::*;
#(
  parameter int WIN_ROUNDS = DEF_WIN_ROUNDS,
  parameter int SCORE_W    = DEF_SCORE_W,
  parameter int CLR_DELAY  = DEF_CLR_DELAY,
  parameter int TIE_W      = DEF_TIE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               winrnd,
  input  logic               right,
  input  logic               tie,
  output logic               clr,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r,
  output logic [TIE_W-1:0]   tie_cnt,
  output logic               match_over,
  output logic               match_right
);

  localparam int CNT_W = cntWidth(CLR_DELAY);
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(CLR_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_ROUNDS);

  tow_state_t         r_state;
  tow_state_t         w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [SCORE_W-1:0] r_score_l;
  logic [SCORE_W-1:0] r_score_r;
  logic [TIE_W-1:0]   r_tie_cnt;
  logic               r_match_right;
  logic               w_rise;
  logic [SCORE_W-1:0] w_score_l_inc;
  logic [SCORE_W-1:0] w_score_r_inc;
  logic               w_win;

  tow_rise_det u_rise_det (
    .clk  (clk),
    .rst  (rst),
    .d    (winrnd),
    .rise (w_rise)
  );

  assign w_score_l_inc = r_score_l + 1'b1;
  assign w_score_r_inc = r_score_r + 1'b1;
  assign w_win = ~tie & (right ? (w_score_r_inc == WIN_VAL) : (w_score_l_inc == WIN_VAL));

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Next-state decode; a tie can never satisfy w_win, so ties always go through HOLD.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_state_next = CLEAR;
      PLAY:       if (w_rise) w_state_next = w_win ? DONE : HOLD;
      HOLD:       if (r_cnt == '0) w_state_next = CLEAR;
      CLEAR:      w_state_next = PLAY;
      default:    w_state_next = IDLE;
    endcase
  end

  // Scores, tie count, winner flag and the result-display delay counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_score_l     <= '0;
      r_score_r     <= '0;
      r_tie_cnt     <= '0;
      r_match_right <= 1'b0;
      r_cnt         <= '0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_score_l     <= '0;
            r_score_r     <= '0;
            r_tie_cnt     <= '0;
            r_match_right <= 1'b0;
          end
        end
        PLAY: begin
          if (w_rise) begin
            if (tie) begin
              if (r_tie_cnt != '1) r_tie_cnt <= r_tie_cnt + 1'b1;
            end else if (right) begin
              r_score_r <= w_score_r_inc;
            end else begin
              r_score_l <= w_score_l_inc;
            end
            if (w_win) r_match_right <= right;
            else       r_cnt         <= CNT_LOAD;
          end
        end
        HOLD: begin
          if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign clr         = (r_state == CLEAR);
  assign match_over  = (r_state == DONE);
  assign score_l     = r_score_l;
  assign score_r     = r_score_r;
  assign tie_cnt     = r_tie_cnt;
  assign match_right = r_match_right;

endmodule

// File: tb/tb_tow_match_ctrl.sv
// Directed self-checking bench for tow_match_ctrl with WIN_ROUNDS=3, CLR_DELAY=4.
module tb_tow_match_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       winrnd;
  logic       right;
  logic       tie;
  logic       clr;
  logic [2:0] score_l;
  logic [2:0] score_r;
  logic [3:0] tie_cnt;
  logic       match_over;
  logic       match_right;

  int total = 0;
  int bad   = 0;

  tow_match_ctrl #(
    .WIN_ROUNDS (3),
    .SCORE_W    (3),
    .CLR_DELAY  (4),
    .TIE_W      (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .winrnd      (winrnd),
    .right       (right),
    .tie         (tie),
    .clr         (clr),
    .score_l     (score_l),
    .score_r     (score_r),
    .tie_cnt     (tie_cnt),
    .match_over  (match_over),
    .match_right (match_right)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance n rising edges; inputs and checks happen 1 unit after each edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic w, input logic r, input logic t);
    start  = s;
    winrnd = w;
    right  = r;
    tie    = t;
  endtask

  // Wait (bounded) for the clr pulse that follows a non-final round; expect it 4 edges after scoring.
  task automatic waitClr(input string tag);
    int lat;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (clr === 1'b1) begin
        lat = i;
        break;
      end
    end
    checkOutput(tag, lat, 4);
  endtask

  // Play one non-final round: raise winrnd, wait for clr, drop winrnd, land in PLAY.
  task automatic playRound(input string tag, input logic r, input logic t);
    applyStimulus(1'b0, 1'b1, r, t);
    tick();
    waitClr(tag);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  // Pulse start from IDLE/DONE and land in PLAY, checking the clr pulse on the way.
  task automatic startMatch(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput(tag, clr, 1);
    start = 1'b0;
    tick();
    checkOutput({tag, "_clr_low"}, clr, 0);
  endtask

  initial begin
    int clrCount;

    // Reset held with winrnd high.
    rst = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick(2);
    checkOutput("rst_clr", clr, 0);
    checkOutput("rst_score_l", score_l, 0);
    checkOutput("rst_score_r", score_r, 0);
    checkOutput("rst_tie_cnt", tie_cnt, 0);
    checkOutput("rst_match_over", match_over, 0);
    checkOutput("rst_match_right", match_right, 0);
    rst = 1'b1;
    tick(2);
    checkOutput("rel_score_l", score_l, 0);
    checkOutput("rel_clr", clr, 0);
    winrnd = 1'b0;
    tick();

    // Single right round with winrnd held for 10 cycles.
    startMatch("single_start");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("single_score_r", score_r, 1);
    checkOutput("single_clr_early", clr, 0);
    clrCount = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      if (clr === 1'b1) clrCount++;
      if (i == 4) checkOutput("single_clr_at4", clr, 1);
    end
    checkOutput("single_clr_count", clrCount, 1);
    checkOutput("single_no_double", score_r, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Match win: three right rounds.
    checkOutput("idle_start_in_play", match_over, 0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    startMatch("win_start");
    playRound("win_r1", 1'b1, 1'b0);
    playRound("win_r2", 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    checkOutput("win_score_r", score_r, 3);
    checkOutput("win_match_over", match_over, 1);
    checkOutput("win_match_right", match_right, 1);
    clrCount = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) winrnd = 1'b0;
      tick();
      if (clr === 1'b1) clrCount++;
    end
    checkOutput("win_no_clr", clrCount, 0);
    checkOutput("win_still_over", match_over, 1);

    // Ties: tie overrides right, then saturation after 16 ties.
    startMatch("tie_start");
    checkOutput("tie_restart_score_r", score_r, 0);
    checkOutput("tie_restart_over", match_over, 0);
    playRound("tie_r1", 1'b1, 1'b1);
    checkOutput("tie_cnt_1", tie_cnt, 1);
    checkOutput("tie_score_r", score_r, 0);
    checkOutput("tie_score_l", score_l, 0);
    for (int i = 0; i < 15; i++) playRound("tie_sat_round", 1'b0, 1'b1);
    checkOutput("tie_sat", tie_cnt, 15);
    checkOutput("tie_not_over", match_over, 0);

    // Mixed match: left, right, left, tie, left.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    startMatch("mix_start");
    playRound("mix_l1", 1'b0, 1'b0);
    playRound("mix_r1", 1'b1, 1'b0);
    playRound("mix_l2", 1'b0, 1'b0);
    playRound("mix_t1", 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("mix_score_l", score_l, 3);
    checkOutput("mix_score_r", score_r, 1);
    checkOutput("mix_tie_cnt", tie_cnt, 1);
    checkOutput("mix_match_over", match_over, 1);
    checkOutput("mix_match_right", match_right, 0);
    winrnd = 1'b0;
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("mix_new_clr", clr, 1);
    checkOutput("mix_new_score_l", score_l, 0);
    checkOutput("mix_new_score_r", score_r, 0);
    checkOutput("mix_new_tie_cnt", tie_cnt, 0);
    checkOutput("mix_new_over", match_over, 0);
    start = 1'b0;
    tick();

    // Reset two cycles into HOLD.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    checkOutput("hold_score_l", score_l, 1);
    tick(2);
    rst = 1'b0;
    tick();
    checkOutput("hold_rst_score_l", score_l, 0);
    checkOutput("hold_rst_clr", clr, 0);
    rst = 1'b1;
    winrnd = 1'b0;
    clrCount = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (clr === 1'b1) clrCount++;
    end
    checkOutput("hold_rst_no_clr", clrCount, 0);
    checkOutput("hold_rst_idle", match_over, 0);

    // Start while in PLAY is ignored.
    startMatch("play_start");
    playRound("play_r1", 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    start = 1'b0;
    checkOutput("play_start_ign_clr", clr, 0);
    checkOutput("play_start_ign_score", score_r, 1);
    tick(3);
    checkOutput("play_start_ign_later", score_r, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
